// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner and fetch stage feeding decode through a 3-entry buffer,
// hiding the instruction memory's one-cycle read latency.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64,
    parameter int          BUF_DEPTH  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pending_pc_q, pending_pc_d;
    logic        pending_q, pending_d;
    logic [31:0] buf_pc_q [BUF_DEPTH];
    logic [31:0] buf_pc_d [BUF_DEPTH];
    logic [31:0] buf_instr_q [BUF_DEPTH];
    logic [31:0] buf_instr_d [BUF_DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [31:0] hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
    logic        issue, push, pop;

    function automatic logic bad_pc(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(IMEM_DEPTH));
    endfunction

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign imem_addr   = {2'b00, pc_q[31:2]};
    assign id_valid    = count_q != 2'd0;
    assign fetch_fault = state_q == FAULT;
    // Head is shown while valid; otherwise the last shown pair is held.
    assign id_pc       = id_valid ? buf_pc_q[rd_ptr_q] : hold_pc_q;
    assign id_instr    = id_valid ? buf_instr_q[rd_ptr_q] : hold_instr_q;

    always_comb begin
        // Counting the in-flight read keeps its response from ever hitting a full buffer.
        issue = (state_q == RUN) && fetch_en && !redirect_valid && !bad_pc(pc_q) &&
                ((3'(count_q) + 3'(pending_q)) < 3'(BUF_DEPTH));
        push = pending_q && !redirect_valid;
        pop = id_valid && id_ready && !redirect_valid;
        pc_d = redirect_valid ? redirect_pc : issue ? pc_q + 32'd4 : pc_q;
        pending_d = issue;
        pending_pc_d = issue ? pc_q : pending_pc_q;
        buf_pc_d = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (push) begin
            buf_pc_d[wr_ptr_q] = pending_pc_q;
            buf_instr_d[wr_ptr_q] = imem_instr;
        end
        wr_ptr_d = redirect_valid ? 2'd0 : push ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = redirect_valid ? 2'd0 : pop ? inc(rd_ptr_q) : rd_ptr_q;
        count_d = redirect_valid ? 2'd0 : count_q + 2'(push) - 2'(pop);
        hold_pc_d = id_pc;
        hold_instr_d = id_instr;
        state_d = state_q;
        if (redirect_valid)
            state_d = bad_pc(redirect_pc) ? FAULT : (state_q == IDLE && !fetch_en) ? IDLE : RUN;
        else if (state_q == IDLE)
            state_d = fetch_en ? RUN : IDLE;
        else if (state_q == RUN && bad_pc(pc_q))
            state_d = FAULT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q <= RESET_PC;
            pending_q <= 1'b0;
            pending_pc_q <= '0;
            buf_pc_q <= '{default: '0};
            buf_instr_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            hold_pc_q <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            pending_q <= pending_d;
            pending_pc_q <= pending_pc_d;
            buf_pc_q <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            hold_pc_q <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scenario tasks plus a randomized stream checked against a
// segment model of the expected (pc, instr) sequence.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        reset, fetch_en, redirect_valid, id_ready, id_valid, fetch_fault;
    logic [31:0] redirect_pc, imem_addr, imem_instr, id_instr, id_pc;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] got [$];

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'h1000_0000 + idx;
    endfunction

    // Synchronous-read memory model.
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    // Records every accepted handshake in order.
    always @(negedge clk)
        if (!reset && !redirect_valid && id_valid && id_ready) got.push_back({id_pc, id_instr});

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic restart;
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        step; step;
        reset = 1'b0;
        got.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        step; step;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", id_valid); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0h exp=0", fetch_fault); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
        checks++; if ({id_pc, id_instr} !== 64'h0) begin failures++; $display("FAIL reset_head got=%0h/%0h exp=0/0", id_pc, id_instr); end
    endtask

    task automatic test_stream;
        restart;
        fetch_en = 1'b1; id_ready = 1'b1;
        step; step;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%0h exp=0", id_valid); end
        step;
        checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, mem_word(0)})
            begin failures++; $display("FAIL first_fetch got=%0h/%0h/%0h exp=1/0/%0h", id_valid, id_pc, id_instr, mem_word(0)); end
        for (int i = 1; i < 20; i++) begin
            step;
            checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'(4 * i), mem_word(32'(i))})
                begin failures++; $display("FAIL stream[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, id_valid, id_pc, id_instr, 4 * i, mem_word(32'(i))); end
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic [31:0] a;
        logic ok;
        restart;
        fetch_en = 1'b1; id_ready = 1'b1;
        repeat (8) step;
        id_ready = 1'b0;
        repeat (5) step;
        n = got.size();
        checks++; if ({id_valid, id_pc} !== {1'b1, 32'(4 * n)}) begin failures++; $display("FAIL bp_head got=%0h/%0h exp=1/%0h", id_valid, id_pc, 4 * n); end
        checks++; if (imem_addr !== 32'(n + 3)) begin failures++; $display("FAIL bp_pc got=%0h exp=%0h", imem_addr, n + 3); end
        a = imem_addr;
        step;
        checks++; if (imem_addr !== a) begin failures++; $display("FAIL bp_no_issue got=%0h exp=%0h", imem_addr, a); end
        fetch_en = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL bp_drain[%0d] got=%0h exp=1", i, id_valid); end
            step;
        end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h exp=0", id_valid); end
        checks++; if ({id_pc, id_instr} !== {32'(4 * (n + 2)), mem_word(32'(n + 2))})
            begin failures++; $display("FAIL bp_hold got=%0h/%0h exp=%0h/%0h", id_pc, id_instr, 4 * (n + 2), mem_word(32'(n + 2))); end
        ok = got.size() == n + 3;
        for (int i = 0; i < got.size(); i++) if (got[i] !== {32'(4 * i), mem_word(32'(i))}) ok = 1'b0;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_order got=%0d entries, in_order=%0b exp=%0d, 1", got.size(), ok, n + 3); end
    endtask

    task automatic test_redirect;
        restart;
        fetch_en = 1'b1;
        repeat (4) step;
        checks++; if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h0, 32'd3})
            begin failures++; $display("FAIL rd_setup got=%0h/%0h/%0h exp=1/0/3", id_valid, id_pc, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
        step;
        redirect_valid = 1'b0;
        checks++; if ({id_valid, imem_addr} !== {1'b0, 32'd16}) begin failures++; $display("FAIL rd_clear got=%0h/%0h exp=0/10", id_valid, imem_addr); end
        step;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rd_gap got=%0h exp=0", id_valid); end
        for (int i = 0; i < 4; i++) begin
            step;
            checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'(32'h40 + 4 * i), mem_word(32'(16 + i))})
                begin failures++; $display("FAIL rd_stream[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, id_valid, id_pc, id_instr, 32'h40 + 4 * i, mem_word(32'(16 + i))); end
        end
        checks++; if (got[0][63:32] !== 32'h40) begin failures++; $display("FAIL rd_no_stale got=%0h exp=40", got[0][63:32]); end
    endtask

    task automatic test_fault_end;
        restart;
        fetch_en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hF0;
        step;
        redirect_valid = 1'b0;
        repeat (12) step;
        checks++; if ({fetch_fault, id_valid} !== 2'b10) begin failures++; $display("FAIL end_fault got=%0b%0b exp=10", fetch_fault, id_valid); end
        checks++; if (imem_addr !== 32'd64) begin failures++; $display("FAIL end_pc got=%0h exp=40", imem_addr); end
        checks++; if (got.size() != 4 || got[got.size() - 1] !== {32'hFC, mem_word(63)})
            begin failures++; $display("FAIL end_last got=%0d entries, last=%0h exp=4, %0h", got.size(), got[got.size() - 1], {32'hFC, mem_word(63)}); end
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        step;
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL end_clear got=%0h exp=0", fetch_fault); end
        step; step;
        checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h8, mem_word(2)})
            begin failures++; $display("FAIL end_resume got=%0h/%0h/%0h exp=1/8/%0h", id_valid, id_pc, id_instr, mem_word(2)); end
    endtask

    task automatic test_misaligned;
        restart;
        fetch_en = 1'b1; id_ready = 1'b1;
        repeat (6) step;
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        step;
        redirect_valid = 1'b0;
        checks++; if ({fetch_fault, id_valid, imem_addr} !== {1'b1, 1'b0, 32'd1})
            begin failures++; $display("FAIL mis_now got=%0h/%0h/%0h exp=1/0/1", fetch_fault, id_valid, imem_addr); end
        repeat (3) step;
        checks++; if ({fetch_fault, id_valid, imem_addr} !== {1'b1, 1'b0, 32'd1})
            begin failures++; $display("FAIL mis_stay got=%0h/%0h/%0h exp=1/0/1", fetch_fault, id_valid, imem_addr); end
    endtask

    task automatic test_reset_mid;
        restart;
        fetch_en = 1'b1;
        repeat (4) step;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL rst_setup got=%0h exp=1", id_valid); end
        reset = 1'b1;
        step;
        checks++; if ({id_valid, imem_addr, fetch_fault, id_pc, id_instr} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0})
            begin failures++; $display("FAIL rst_mid got=%0h/%0h/%0h/%0h/%0h exp=0/0/0/0/0", id_valid, imem_addr, fetch_fault, id_pc, id_instr); end
        reset = 1'b0; id_ready = 1'b1;
        step; step; step;
        checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, mem_word(0)})
            begin failures++; $display("FAIL rst_restart got=%0h/%0h/%0h exp=1/0/%0h", id_valid, id_pc, id_instr, mem_word(0)); end
        step;
        checks++; if ({id_valid, id_pc} !== {1'b1, 32'h4}) begin failures++; $display("FAIL rst_next got=%0h/%0h exp=1/4", id_valid, id_pc); end
    endtask

    // Each redirect opens a segment; entries within one must run start, start+4, ...
    task automatic test_random;
        int seg_start [$];
        int seg_idx [$];
        int j;
        logic [31:0] exp_pc;
        restart;
        seg_start.push_back(0);
        seg_idx.push_back(0);
        for (int c = 0; c < 400; c++) begin
            fetch_en = ($urandom % 4) != 0;
            id_ready = ($urandom % 3) != 0;
            if ($urandom % 40 == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'(4 * $urandom_range(0, 50));
                seg_idx.push_back(got.size());
                seg_start.push_back(int'(redirect_pc));
            end else redirect_valid = 1'b0;
            step;
        end
        redirect_valid = 1'b0;
        checks++; if (got.size() < 100) begin failures++; $display("FAIL rand_progress got=%0d exp>=100", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            j = 0;
            for (int s = 0; s < seg_idx.size(); s++) if (seg_idx[s] <= i) j = s;
            exp_pc = 32'(seg_start[j] + 4 * (i - seg_idx[j]));
            checks++; if (got[i] !== {exp_pc, mem_word(exp_pc >> 2)})
                begin failures++; $display("FAIL rand[%0d] got=%0h exp=%0h", i, got[i], {exp_pc, mem_word(exp_pc >> 2)}); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_fault_end;
        test_misaligned;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
